fir_out_requant: RTL and testbench
==================================

FIR_OUT_REQUANT -- requirements
Module: fir_out_requant

Interface
REQ-001 The block SHALL have parameter DECIM, default 4, giving the decimation ratio (legal range 1..16).
REQ-002 The block SHALL have parameter SHIFT, default 15, giving the right-shift applied to each filter output (legal range 1..16).
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the output FIFO depth (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 y_valid  input  1  one-cycle strobe; y_in carries a new filter output this cycle.
REQ-007 y_in  input  32  signed filter output sample.
REQ-008 ovf_clr  input  1  clears the sticky ovf flag.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_valid  output  1  out_data holds an unread sample.
REQ-011 out_data  output  16  signed requantised, decimated sample.
REQ-012 ovf  output  1  sticky flag; a kept sample was dropped because the FIFO was full.

Function
REQ-013 A phase counter (0..DECIM-1) SHALL advance on each y_valid and wrap from DECIM-1 to 0; only samples arriving at phase 0 SHALL be kept.
REQ-014 A kept sample SHALL be sign-extended to 33 bits, have 2^(SHIFT-1) added (round half up), and be arithmetically shifted right by SHIFT.
REQ-015 The shifted value SHALL saturate to [-32768, 32767]; no wrap-around is permitted.
REQ-016 The requantised result SHALL be registered one cycle after the y_valid that kept it, then written to the FIFO on the following edge.
REQ-017 With the FIFO empty, out_valid SHALL rise exactly 2 cycles after the keeping y_valid.
REQ-018 A pop SHALL occur when out_valid and out_ready are both high; out_data SHALL show the FIFO head and be stable while out_valid=1 and out_ready=0.
REQ-019 A push and a pop in the same cycle while the FIFO is full SHALL both succeed, with no drop.
REQ-020 A push while the FIFO is full and no pop occurs SHALL discard the new sample, leave FIFO contents unchanged, and set ovf.
REQ-021 ovf SHALL remain set until ovf_clr or rst; if a set condition and ovf_clr coincide, ovf SHALL stay 1.
REQ-022 A pop on an empty FIFO is impossible by construction (out_valid=0); out_ready SHALL be ignored when the FIFO is empty.
REQ-023 With DECIM=1, every y_valid SHALL be kept.

Reset
REQ-024 rst SHALL clear the phase counter, pipeline register valid bit, FIFO pointers, and ovf; after reset, out_valid=0, out_data=0, and ovf=0.
REQ-025 rst asserted mid-operation SHALL discard all in-flight and queued samples; the first y_valid after rst SHALL be phase 0.

Configuration
REQ-026 Macro FIR_OUT_REQUANT_SATCNT_EN, when defined, SHALL add output sat_cnt (16 bits): it counts kept samples that saturated, holds at 65535, and clears on rst or ovf_clr.
REQ-027 Without FIR_OUT_REQUANT_SATCNT_EN, the sat_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 The shared package fir_pkg SHALL hold the sample widths (16-bit input, 32-bit product/output) and the saturation limit constants.
REQ-029 The FIFO SHALL be one sub-module, fir_out_fifo (parameters DEPTH and width 16, with full/empty flags); rounding, saturation, and decimation SHALL stay in the top module.

Verification
REQ-030 DECIM=4, SHIFT=15: feed y_in=16384 on 8 consecutive y_valid strobes -> exactly 2 outputs, each 1, with out_valid rising 2 cycles after strobes 1 and 5.
REQ-031 DECIM=1: y_in=0x7FFFFFFF -> 32767; y_in=0x80000000 -> -32768; y_in=-16385 -> -1 (with sat_cnt=2 when the macro is defined).
REQ-032 Hold out_ready=0, DEPTH=4, DECIM=1, feed 5 samples 1..5 (in units of 2^15) -> 4 outputs 1..4 are held, sample 5 is dropped, ovf=1; ovf_clr -> ovf=0.
REQ-033 FIFO full and out_ready=1 while a new sample arrives -> no drop, ovf stays 0, and output order is preserved.
REQ-034 Assert rst for one cycle with 2 samples queued and 1 in flight -> out_valid=0 the next cycle; the next sample is kept as phase 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths and saturation limits for the FIR output path.
package fir_pkg;

  // Requantised output sample width and filter product/output width.
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned ACC_W    = 32;

  // Saturation limits for a signed SAMPLE_W result.
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

endpackage

// File: rtl/fir_out_fifo.sv
// Output FIFO for requantised samples. A push into a full FIFO is accepted
// only when a pop happens on the same edge; the head reads as zero while empty.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             wr_en, rd_en;

  // Flags, accepted push/pop and head view.
  always_comb begin
    full_o  = (cnt_q == (AW+1)'(DEPTH));
    empty_o = (cnt_q == '0);
    wr_en   = push_i && (!full_o || pop_i);
    rd_en   = pop_i && !empty_o;
    dout_o  = empty_o ? '0 : mem_q[rd_q];
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (rd_en) rd_q <= rd_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage write; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/fir_out_requant.sv
// Decimates, rounds (half up), shifts and saturates filter output samples to
// 16 bits, then queues them in an output FIFO with a sticky overflow flag.
// Optional FIR_OUT_REQUANT_SATCNT_EN adds a saturating count of clipped samples.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int unsigned DECIM = 4,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       y_valid,
  input  logic signed [ACC_W-1:0]    y_in,
  input  logic                       ovf_clr,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_data,
  output logic                       ovf
`ifdef FIR_OUT_REQUANT_SATCNT_EN
  ,
  output logic [15:0]                sat_cnt
`endif
);

  localparam int unsigned PH_W = 4;
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W:0] HI  = (ACC_W+1)'(SAT_MAX);
  localparam logic signed [ACC_W:0] LO  = (ACC_W+1)'(SAT_MIN);

  logic [PH_W-1:0]          phase_q, phase_d;
  logic                     keep;
  logic signed [ACC_W:0]    y_ext, y_rnd, y_shr;
  logic                     sat;
  sample_t                  y_sat;
  logic                     pipe_vld_q;
  sample_t                  pipe_dat_q;
  logic                     ovf_q, ovf_d;
  logic                     pop, full, empty;

  // Phase tracking: only the sample arriving at phase 0 is kept.
  always_comb begin
    keep    = y_valid && (phase_q == '0);
    phase_d = phase_q;
    if (y_valid) begin
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
    end
  end

  // Round half up in 33 bits so the offset cannot overflow, then clip.
  always_comb begin
    y_ext = {y_in[ACC_W-1], y_in};
    y_rnd = y_ext + RND;
    y_shr = y_rnd >>> SHIFT;
    sat   = 1'b0;
    if (y_shr > HI) begin
      y_sat = SAMPLE_W'(SAT_MAX);
      sat   = 1'b1;
    end else if (y_shr < LO) begin
      y_sat = SAMPLE_W'(SAT_MIN);
      sat   = 1'b1;
    end else begin
      y_sat = y_shr[SAMPLE_W-1:0];
    end
  end

  // Phase counter and one-stage result register ahead of the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      pipe_vld_q <= 1'b0;
      pipe_dat_q <= '0;
    end else begin
      phase_q    <= phase_d;
      pipe_vld_q <= keep;
      if (keep) pipe_dat_q <= y_sat;
    end
  end

  fir_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pipe_vld_q),
    .pop_i   (pop),
    .din_i   (pipe_dat_q),
    .dout_o  (out_data),
    .full_o  (full),
    .empty_o (empty)
  );

  // Handshake and sticky overflow next state; a set beats a clear.
  always_comb begin
    out_valid = !empty;
    pop       = out_valid && out_ready;
    ovf_d     = ovf_q;
    if (pipe_vld_q && full && !pop) ovf_d = 1'b1;
    else if (ovf_clr)               ovf_d = 1'b0;
    ovf       = ovf_q;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

`ifdef FIR_OUT_REQUANT_SATCNT_EN
  logic        pipe_sat_q;
  logic [15:0] sat_cnt_q;

  // Saturation count of kept samples, holding at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_sat_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      pipe_sat_q <= keep && sat;
      if (ovf_clr)                             sat_cnt_q <= '0;
      else if (pipe_sat_q && sat_cnt_q != '1)  sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = sat;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: a DECIM=4 and a DECIM=1 instance.
module tb_fir_out_requant;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        y_valid4, ovf_clr4, out_ready4, out_valid4, ovf4;
  logic [31:0] y_in4;
  logic [15:0] out_data4;
  logic        y_valid1, ovf_clr1, out_ready1, out_valid1, ovf1;
  logic [31:0] y_in1;
  logic [15:0] out_data1;
`ifdef FIR_OUT_REQUANT_SATCNT_EN
  logic [15:0] sat_cnt4, sat_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  fir_out_requant #(.DECIM(4), .SHIFT(15), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .y_valid(y_valid4), .y_in(y_in4), .ovf_clr(ovf_clr4),
    .out_ready(out_ready4), .out_valid(out_valid4), .out_data(out_data4), .ovf(ovf4)
`ifdef FIR_OUT_REQUANT_SATCNT_EN
    , .sat_cnt(sat_cnt4)
`endif
  );

  fir_out_requant #(.DECIM(1), .SHIFT(15), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .y_valid(y_valid1), .y_in(y_in1), .ovf_clr(ovf_clr1),
    .out_ready(out_ready1), .out_valid(out_valid1), .out_data(out_data1), .ovf(ovf1)
`ifdef FIR_OUT_REQUANT_SATCNT_EN
    , .sat_cnt(sat_cnt1)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    y_valid4 = 1'b0; y_in4 = '0; ovf_clr4 = 1'b0; out_ready4 = 1'b0;
    y_valid1 = 1'b0; y_in1 = '0; ovf_clr1 = 1'b0; out_ready1 = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_valid4 got=%b want=0", out_valid4); end
    total++; if (out_data4 !== 16'h0) begin bad++; $display("FAIL reset_data4 got=%h want=0000", out_data4); end
    total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL reset_ovf4 got=%b want=0", ovf4); end
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b want=0", out_valid1); end
    total++; if (out_data1 !== 16'h0) begin bad++; $display("FAIL reset_data1 got=%h want=0000", out_data1); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL reset_ovf1 got=%b want=0", ovf1); end
  endtask

  // 8 strobes of 16384 at DECIM=4: outputs of 1 visible after edges 2 and 6.
  task automatic test_decim;
    int  nout;
    logic exp_v;
    do_reset;
    nout = 0;
    out_ready4 = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      y_valid4 = (t <= 8);
      y_in4    = 32'd16384;
      if (out_valid4 && out_ready4) begin
        nout++;
        total++; if (out_data4 !== 16'd1) begin bad++; $display("FAIL decim_data got=%h want=0001", out_data4); end
      end
      tick;
      exp_v = (t == 2) || (t == 6);
      total++; if (out_valid4 !== exp_v) begin bad++; $display("FAIL decim_valid edge=%0d got=%b want=%b", t, out_valid4, exp_v); end
    end
    y_valid4 = 1'b0;
    total++; if (nout != 2) begin bad++; $display("FAIL decim_count got=%0d want=2", nout); end
  endtask

  // DECIM=1 rounding and saturation at both rails.
  task automatic test_sat;
    logic [31:0] vin [3];
    logic [15:0] vexp [3];
    int n;
    vin[0] = 32'h7FFF_FFFF; vin[1] = 32'h8000_0000; vin[2] = 32'hFFFF_BFFF;
    vexp[0] = 16'h7FFF;     vexp[1] = 16'h8000;     vexp[2] = 16'hFFFF;
    do_reset;
    out_ready1 = 1'b1;
    n = 0;
    for (int t = 0; t < 8; t++) begin
      y_valid1 = (t < 3);
      y_in1    = (t < 3) ? vin[t] : '0;
      if (out_valid1 && out_ready1) begin
        total++;
        if (n >= 3) begin bad++; $display("FAIL sat_extra got=%h want=none", out_data1); end
        else if (out_data1 !== vexp[n]) begin bad++; $display("FAIL sat_data idx=%0d got=%h want=%h", n, out_data1, vexp[n]); end
        n++;
      end
      tick;
    end
    total++; if (n != 3) begin bad++; $display("FAIL sat_count got=%0d want=3", n); end
`ifdef FIR_OUT_REQUANT_SATCNT_EN
    total++; if (sat_cnt1 !== 16'd2) begin bad++; $display("FAIL sat_cnt got=%0d want=2", sat_cnt1); end
`endif
  endtask

  // Five samples into a depth-4 FIFO with no consumer: fifth dropped, ovf set.
  task automatic test_ovf;
    int n;
    do_reset;
    out_ready1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      y_valid1 = 1'b1;
      y_in1    = 32'(k) << 15;
      tick;
      if (k >= 2) begin
        total++; if (out_valid1 !== 1'b1 || out_data1 !== 16'd1) begin
          bad++; $display("FAIL ovf_hold edge=%0d got=%b/%h want=1/0001", k, out_valid1, out_data1);
        end
      end
    end
    y_valid1 = 1'b0;
    tick;
    tick;
    total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf1); end
    total++; if (out_data1 !== 16'd1) begin bad++; $display("FAIL ovf_head got=%h want=0001", out_data1); end
    ovf_clr1 = 1'b1;
    tick;
    ovf_clr1 = 1'b0;
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", ovf1); end
    out_ready1 = 1'b1;
    n = 0;
    for (int t = 0; t < 7; t++) begin
      if (out_valid1 && out_ready1) begin
        total++;
        if (n >= 4) begin bad++; $display("FAIL ovf_extra got=%h want=none", out_data1); end
        else if (out_data1 !== 16'(n + 1)) begin bad++; $display("FAIL ovf_drain idx=%0d got=%h want=%h", n, out_data1, 16'(n + 1)); end
        n++;
      end
      tick;
    end
    total++; if (n != 4) begin bad++; $display("FAIL ovf_drain_count got=%0d want=4", n); end
  endtask

  // Push into a full FIFO on the same edge as a pop: nothing lost.
  task automatic test_full_pushpop;
    int n;
    do_reset;
    out_ready1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      y_valid1 = 1'b1;
      y_in1    = 32'(10 + k) << 15;
      tick;
    end
    y_valid1 = 1'b0;
    tick;
    total++; if (out_valid1 !== 1'b1 || out_data1 !== 16'd10) begin
      bad++; $display("FAIL full_head got=%b/%h want=1/000a", out_valid1, out_data1);
    end
    y_valid1 = 1'b1;
    y_in1    = 32'd14 << 15;
    tick;
    y_valid1   = 1'b0;
    out_ready1 = 1'b1;
    n = 0;
    for (int t = 0; t < 8; t++) begin
      if (out_valid1 && out_ready1) begin
        total++;
        if (n >= 5) begin bad++; $display("FAIL full_extra got=%h want=none", out_data1); end
        else if (out_data1 !== 16'(10 + n)) begin bad++; $display("FAIL full_order idx=%0d got=%h want=%h", n, out_data1, 16'(10 + n)); end
        n++;
      end
      tick;
    end
    total++; if (n != 5) begin bad++; $display("FAIL full_count got=%0d want=5", n); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL full_ovf got=%b want=0", ovf1); end
  endtask

  // Reset with two queued and one in flight, then restart at phase 0.
  task automatic test_rst_mid;
    do_reset;
    out_ready4 = 1'b0;
    for (int s = 1; s <= 9; s++) begin
      y_valid4 = 1'b1;
      y_in4    = (s == 1) ? (32'd1 << 15) : (s == 5) ? (32'd2 << 15) : (32'd3 << 15);
      tick;
    end
    y_valid4 = 1'b0;
    total++; if (out_valid4 !== 1'b1 || out_data4 !== 16'd1) begin
      bad++; $display("FAIL mid_queued got=%b/%h want=1/0001", out_valid4, out_data4);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid4); end
    tick;
    tick;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL mid_inflight got=%b want=0", out_valid4); end
    y_valid4 = 1'b1;
    y_in4    = 32'd7 << 15;
    tick;
    y_valid4 = 1'b0;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL mid_early got=%b want=0", out_valid4); end
    tick;
    total++; if (out_valid4 !== 1'b1 || out_data4 !== 16'd7) begin
      bad++; $display("FAIL mid_phase0 got=%b/%h want=1/0007", out_valid4, out_data4);
    end
  endtask

  initial begin
    test_reset;
    test_decim;
    test_sat;
    test_ovf;
    test_full_pushpop;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
